// File: rtl/stage_exe_hs.sv
// Flow-controlled execute stage: single-cycle ALU ops plus an iterative shift-add MUL.
// Results land in one output slot with a valid/ready handshake to memory/writeback.
module stage_exe_hs #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ILEN   = 32,
  parameter int unsigned OP_LSB = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic            busy
);

  localparam int unsigned SW = $clog2(XLEN);
  localparam int unsigned CW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_SLL = 5'd5;
  localparam logic [4:0] OP_SRL = 5'd6;
  localparam logic [4:0] OP_MUL = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] a_sh_q, a_sh_d;
  logic [XLEN-1:0] b_sh_q, b_sh_d;
  logic [ILEN-1:0] m_instr_q, m_instr_d;
  logic [XLEN-1:0] m_a_q, m_a_d;
  logic [XLEN-1:0] m_b_q, m_b_d;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;

  logic [4:0]      op;
  logic            slot_free;
  logic            accept;
  logic [XLEN-1:0] alu_res;

  assign op        = in_instr[OP_LSB +: 5];
  assign slot_free = !valid_q || out_ready;
  assign in_ready  = (state_q == ST_IDLE) && slot_free && !flush;
  assign accept    = in_valid && in_ready;

  assign out_valid  = valid_q;
  assign out_result = res_q;
  assign out_instr  = instr_q;
  assign out_a      = a_q;
  assign out_b      = b_q;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    alu_res = in_a;
    case (op)
      OP_ADD:  alu_res = in_a + in_b;
      OP_SUB:  alu_res = in_a - in_b;
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SLL:  alu_res = in_a << in_b[SW-1:0];
      OP_SRL:  alu_res = in_a >> in_b[SW-1:0];
      default: alu_res = in_a;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    m_instr_d = m_instr_q;
    m_a_d     = m_a_q;
    m_b_d     = m_b_q;
    valid_d   = valid_q;
    res_d     = res_q;
    instr_d   = instr_q;
    a_d       = a_q;
    b_d       = b_q;

    // A drain empties the slot unless a write below refills it in the same cycle.
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            state_d   = ST_MUL;
            cnt_d     = '0;
            acc_d     = '0;
            a_sh_d    = in_a;
            b_sh_d    = in_b;
            m_instr_d = in_instr;
            m_a_d     = in_a;
            m_b_d     = in_b;
          end else begin
            valid_d = 1'b1;
            res_d   = alu_res;
            instr_d = in_instr;
            a_d     = in_a;
            b_d     = in_b;
          end
        end
      end
      ST_MUL: begin
        if (b_sh_q[0]) begin
          acc_d = acc_q + a_sh_q;
        end
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (slot_free) begin
          valid_d = 1'b1;
          res_d   = acc_q;
          instr_d = m_instr_q;
          a_d     = m_a_q;
          b_d     = m_b_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      m_instr_q <= '0;
      m_a_q     <= '0;
      m_b_q     <= '0;
      valid_q   <= 1'b0;
      res_q     <= '0;
      instr_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      m_instr_q <= m_instr_d;
      m_a_q     <= m_a_d;
      m_b_q     <= m_b_d;
      valid_q   <= valid_d;
      res_q     <= res_d;
      instr_q   <= instr_d;
      a_q       <= a_d;
      b_q       <= b_d;
    end
  end

endmodule

// File: tb/tb_stage_exe_hs.sv
// Self-checking bench for stage_exe_hs: directed vector table, multi-cycle corner
// sequences, and a randomized stream scored against a transaction-level model.
module tb_stage_exe_hs;
  localparam int XLEN   = 32;
  localparam int ILEN   = 32;
  localparam int OP_LSB = 7;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [ILEN-1:0] in_instr, out_instr;
  logic [XLEN-1:0] in_a, in_b, out_result, out_a, out_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] a, b, r;
  } exp_t;
  exp_t sbq[$];

  bit              hold_v = 0;
  logic [XLEN-1:0] hold_r, hold_a, hold_b;
  logic [ILEN-1:0] hold_i;

  always #5 clk = ~clk;

  stage_exe_hs #(.XLEN(XLEN), .ILEN(ILEN), .OP_LSB(OP_LSB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_instr(out_instr), .out_a(out_a), .out_b(out_b), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] model(input logic [ILEN-1:0] instr,
                                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int unsigned      op;
    int unsigned      sh;
    longint unsigned  p;
    op = instr[OP_LSB +: 5];
    sh = b % XLEN;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << sh;
      6: return a >> sh;
      7: begin
        p = longint'(a) * longint'(b);
        return p[XLEN-1:0];
      end
      default: return a;
    endcase
  endfunction

  function automatic logic [ILEN-1:0] mk(input int unsigned op);
    logic [ILEN-1:0] w;
    w = 32'hABCD_E033;
    w[OP_LSB +: 5] = op[4:0];
    return w;
  endfunction

  function automatic logic [XLEN-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One clock: evaluate handshakes for the coming edge, score them, then advance to the next negedge.
  task automatic cycle();
    bit   acc, drn;
    exp_t e;
    #1;
    if (hold_v) begin
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_result", out_result, hold_r);
      chk("stall_instr", out_instr, hold_i);
      chk("stall_a", out_a, hold_a);
      chk("stall_b", out_b, hold_b);
    end
    chk("in_ready_rule", in_ready, !busy && (!out_valid || out_ready) && !flush);
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (drn) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out: out_valid=1 result=%h, expected no pending result", out_result);
      end else begin
        e = sbq.pop_front();
        chk("sb_result", out_result, e.r);
        chk("sb_instr", out_instr, e.instr);
        chk("sb_a", out_a, e.a);
        chk("sb_b", out_b, e.b);
      end
    end
    if (flush) sbq.delete();
    if (acc) begin
      e.instr = in_instr;
      e.a     = in_a;
      e.b     = in_b;
      e.r     = model(in_instr, in_a, in_b);
      sbq.push_back(e);
    end
    hold_v = out_valid && !out_ready && !flush;
    hold_r = out_result;
    hold_i = out_instr;
    hold_a = out_a;
    hold_b = out_b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_result", out_result, '0);
    chk("rst_out_instr", out_instr, '0);
    chk("rst_out_a", out_a, '0);
    chk("rst_out_b", out_b, '0);
    chk("rst_busy", busy, 1'b0);
    sbq.delete();
    hold_v    = 0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
  endtask

  typedef struct {
    int unsigned     op;
    logic [XLEN-1:0] a, b, r;
  } vec_t;
  vec_t vecs[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vecs[0]  = '{0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    vecs[1]  = '{1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[2]  = '{2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[3]  = '{3,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0};
    vecs[4]  = '{4,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
    vecs[5]  = '{5,  32'h0000_0001, 32'd31,        32'h8000_0000};
    vecs[6]  = '{5,  32'h0000_0001, 32'd35,        32'h0000_0008};
    vecs[7]  = '{6,  32'h8000_0000, 32'd31,        32'h0000_0001};
    vecs[8]  = '{6,  32'hF000_0000, 32'd4,         32'h0F00_0000};
    vecs[9]  = '{9,  32'h1234_5678, 32'h0000_0042, 32'h1234_5678};
    vecs[10] = '{31, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hDEAD_BEEF};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_a = '0; in_b = '0;
    #1 rst = 1'b1;
    #2;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_result", out_result, '0);
    chk("reset_out_instr", out_instr, '0);
    chk("reset_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    // Back-to-back single-cycle ops with the consumer always ready.
    foreach (vecs[i]) begin
      in_valid = 1'b1;
      in_instr = mk(vecs[i].op);
      in_a     = vecs[i].a;
      in_b     = vecs[i].b;
      #1;
      chk("stream_in_ready", in_ready, 1'b1);
      cycle();
      chk("vec_valid", out_valid, 1'b1);
      chk("vec_result", out_result, vecs[i].r);
      chk("vec_instr", out_instr, mk(vecs[i].op));
      chk("vec_a", out_a, vecs[i].a);
      chk("vec_b", out_b, vecs[i].b);
    end
    in_valid = 1'b0;
    cycle();
    chk("stream_drained", out_valid, 1'b0);

    // MUL latency and results.
    in_valid = 1'b1; in_instr = mk(7); in_a = 32'h0001_0003; in_b = 32'h0000_0005;
    cycle();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (lat == 0 || lat == 16 || lat == 32) begin
        chk("mul_busy", busy, 1'b1);
        chk("mul_in_ready", in_ready, 1'b0);
      end
      cycle();
      lat++;
    end
    chk("mul_latency", lat, 33);
    chk("mul_result", out_result, 32'h0005_000F);
    chk("mul_busy_after", busy, 1'b0);
    in_valid = 1'b1; in_instr = mk(7); in_a = '1; in_b = '1;
    cycle();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      cycle();
      lat++;
    end
    chk("mul2_latency", lat, 33);
    chk("mul2_result", out_result, 32'h0000_0001);
    cycle();

    // Back-pressure: slot held, no accept, then drain and refill in one cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = mk(0); in_a = 32'd5; in_b = 32'd6;
    cycle();
    in_instr = mk(1); in_a = 32'd100; in_b = 32'd1;
    repeat (3) begin
      #1;
      chk("bp_in_ready", in_ready, 1'b0);
      cycle();
      chk("bp_result", out_result, 32'd11);
    end
    out_ready = 1'b1;
    in_instr = mk(0); in_a = 32'd1; in_b = 32'd2;
    cycle();
    chk("bp_refill_valid", out_valid, 1'b1);
    chk("bp_refill_result", out_result, 32'd3);
    in_valid = 1'b0;
    cycle();
    chk("bp_drain", out_valid, 1'b0);

    // Flush a full, stalled slot.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = mk(4); in_a = 32'h1; in_b = 32'h3;
    cycle();
    in_valid = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_slot_valid", out_valid, 1'b0);

    // Flush mid-MUL, then the stage must accept and compute normally.
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = mk(7); in_a = 32'd7; in_b = 32'd9;
    cycle();
    in_valid = 1'b0;
    repeat (10) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_mul_valid", out_valid, 1'b0);
    chk("flush_mul_busy", busy, 1'b0);
    #1;
    chk("flush_in_ready", in_ready, 1'b1);
    repeat (40) cycle();
    chk("flush_no_ghost", out_valid, 1'b0);
    in_valid = 1'b1; in_instr = mk(0); in_a = 32'h100; in_b = 32'h23;
    cycle();
    in_valid = 1'b0;
    chk("post_flush_result", out_result, 32'h123);
    cycle();

    // Asynchronous reset with a stalled slot, then mid-MUL.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = mk(3); in_a = 32'h55; in_b = 32'hAA00;
    cycle();
    in_valid = 1'b0;
    async_reset();
    in_valid = 1'b1; in_instr = mk(7); in_a = 32'd3; in_b = 32'd3;
    cycle();
    in_valid = 1'b0;
    repeat (5) cycle();
    async_reset();
    repeat (40) cycle();
    chk("rst_no_partial", out_valid, 1'b0);

    // Randomized stream against the transaction model.
    for (int n = 0; n < 3000; n++) begin
      int unsigned r, op;
      r = $urandom_range(0, 15);
      if (r < 8)       op = r;
      else if (r < 10) op = $urandom_range(8, 31);
      else             op = $urandom_range(0, 6);
      in_valid = ($urandom_range(0, 3) != 0);
      in_instr = $urandom;
      in_instr[OP_LSB +: 5] = op[4:0];
      in_a      = rnd_val();
      in_b      = rnd_val();
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (40) cycle();
    chk("sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
